// File: rtl/kbd_drive_decoder_pkg.sv
// kbd_drive_decoder_pkg: shared drive-code encodings, scan codes, key indices and parser states
package kbd_drive_decoder_pkg;
  localparam logic [1:0] H_NONE = 2'd0;
  localparam logic [1:0] H_LEFT = 2'd1;
  localparam logic [1:0] H_RIGHT = 2'd2;
  localparam logic [1:0] V_NONE = 2'd0;
  localparam logic [1:0] V_UP = 2'd1;
  localparam logic [1:0] V_DOWN = 2'd2;
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_LEFT = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP = 8'h75;
  localparam logic [7:0] SC_DOWN = 8'h72;
  localparam int K_A = 0;
  localparam int K_D = 1;
  localparam int K_W = 2;
  localparam int K_S = 3;
  localparam int K_LSHIFT = 4;
  localparam int K_LEFT = 5;
  localparam int K_RIGHT = 6;
  localparam int K_UP = 7;
  localparam int K_DOWN = 8;
  localparam int K_RSHIFT = 9;
  localparam int K_ENTER = 10;
  typedef enum logic [2:0] {P_IDLE, P_E0, P_F0, P_E0F0, P_SKIP} p_state_t;
  function automatic logic [10:0] key_mask(input logic [7:0] code, input logic ext);
    key_mask = '0;
    if (!ext) begin
      case (code)
        SC_A: key_mask[K_A] = 1'b1;
        SC_D: key_mask[K_D] = 1'b1;
        SC_W: key_mask[K_W] = 1'b1;
        SC_S: key_mask[K_S] = 1'b1;
        SC_LSHIFT: key_mask[K_LSHIFT] = 1'b1;
        SC_RSHIFT: key_mask[K_RSHIFT] = 1'b1;
        SC_ENTER: key_mask[K_ENTER] = 1'b1;
        default: key_mask = '0;
      endcase
    end else begin
      case (code)
        SC_LEFT: key_mask[K_LEFT] = 1'b1;
        SC_RIGHT: key_mask[K_RIGHT] = 1'b1;
        SC_UP: key_mask[K_UP] = 1'b1;
        SC_DOWN: key_mask[K_DOWN] = 1'b1;
        default: key_mask = '0;
      endcase
    end
  endfunction
  function automatic logic [1:0] resolve(input logic a, input logic b);
    resolve = (a && !b) ? 2'd1 : (b && !a) ? 2'd2 : 2'd0;
  endfunction
endpackage

// File: rtl/kbd_event_parser.sv
// kbd_event_parser: turns set-2 scan-code bytes into make/break events with prefix timeout and Pause skip
module kbd_event_parser
  import kbd_drive_decoder_pkg::*;
#(
  parameter int unsigned PREFIX_TIMEOUT = 1_000_000,
  parameter logic [2:0] PAUSE_SKIP = 3'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       rx_err,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break
);
  p_state_t state, state_nx;
  logic [31:0] tcnt, tcnt_nx;
  logic [2:0] skip, skip_nx;
  logic prefix;
  // parser state, prefix timeout and skip counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= P_IDLE;
      tcnt <= '0;
      skip <= '0;
    end else begin
      state <= state_nx;
      tcnt <= tcnt_nx;
      skip <= skip_nx;
    end
  end
  // byte decode; an error abandons any sequence and beats a same-cycle byte
  always_comb begin
    state_nx = state;
    tcnt_nx = tcnt;
    skip_nx = skip;
    evt_valid = 1'b0;
    evt_code = rx_byte;
    evt_ext = 1'b0;
    evt_break = 1'b0;
    prefix = (state == P_E0) || (state == P_F0) || (state == P_E0F0);
    if (rx_err) begin
      state_nx = P_IDLE;
      tcnt_nx = '0;
      skip_nx = '0;
    end else if (rx_valid) begin
      tcnt_nx = '0;
      case (state)
        P_IDLE: begin
          if (rx_byte == SC_E0) state_nx = P_E0;
          else if (rx_byte == SC_F0) state_nx = P_F0;
          else if (rx_byte == SC_E1) begin
            state_nx = P_SKIP;
            skip_nx = PAUSE_SKIP;
          end else evt_valid = 1'b1;
        end
        P_E0: begin
          if (rx_byte == SC_F0) state_nx = P_E0F0;
          else if (rx_byte != SC_E0) begin
            evt_valid = 1'b1;
            evt_ext = 1'b1;
            state_nx = P_IDLE;
          end
        end
        P_F0: begin
          evt_valid = 1'b1;
          evt_break = 1'b1;
          state_nx = P_IDLE;
        end
        P_E0F0: begin
          evt_valid = 1'b1;
          evt_ext = 1'b1;
          evt_break = 1'b1;
          state_nx = P_IDLE;
        end
        P_SKIP: begin
          skip_nx = (skip == 3'd0) ? 3'd0 : skip - 3'd1;
          state_nx = (skip <= 3'd1) ? P_IDLE : P_SKIP;
        end
        default: state_nx = P_IDLE;
      endcase
    end else if (prefix) begin
      tcnt_nx = (tcnt == PREFIX_TIMEOUT - 1) ? '0 : tcnt + 32'd1;
      state_nx = (tcnt == PREFIX_TIMEOUT - 1) ? P_IDLE : state;
    end
  end
endmodule

// File: rtl/kbd_drive_decoder.sv
// kbd_drive_decoder: key bitmap and resolved two-player drive commands from a PS/2 byte stream
module kbd_drive_decoder
  import kbd_drive_decoder_pkg::*;
#(
  parameter int unsigned PREFIX_TIMEOUT = 1_000_000,
  parameter logic [2:0] PAUSE_SKIP = 3'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       rx_err,
  output logic [1:0] p1_h_code,
  output logic [1:0] p1_v_code,
  output logic       p1_boost,
  output logic [1:0] p2_h_code,
  output logic [1:0] p2_v_code,
  output logic       p2_boost,
  output logic       start_pulse
);
  logic evt_valid, evt_ext, evt_break;
  logic [7:0] evt_code;
  logic [10:0] keys, keys_nx, mask;
  kbd_event_parser #(.PREFIX_TIMEOUT(PREFIX_TIMEOUT), .PAUSE_SKIP(PAUSE_SKIP)) parser (
    .clk(clk),
    .rst(rst),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte),
    .rx_err(rx_err),
    .evt_valid(evt_valid),
    .evt_code(evt_code),
    .evt_ext(evt_ext),
    .evt_break(evt_break)
  );
  // next bitmap; outputs are resolved from it so they land together with the bitmap
  always_comb begin
    mask = key_mask(evt_code, evt_ext);
    keys_nx = !evt_valid ? keys : evt_break ? (keys & ~mask) : (keys | mask);
  end
  // bitmap and output registers; start fires only on a fresh Enter press
  always_ff @(posedge clk) begin
    if (rst) begin
      keys <= '0;
      p1_h_code <= H_NONE;
      p1_v_code <= V_NONE;
      p1_boost <= 1'b0;
      p2_h_code <= H_NONE;
      p2_v_code <= V_NONE;
      p2_boost <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      keys <= keys_nx;
      p1_h_code <= resolve(keys_nx[K_A], keys_nx[K_D]);
      p1_v_code <= resolve(keys_nx[K_W], keys_nx[K_S]);
      p1_boost <= keys_nx[K_LSHIFT];
      p2_h_code <= resolve(keys_nx[K_LEFT], keys_nx[K_RIGHT]);
      p2_v_code <= resolve(keys_nx[K_UP], keys_nx[K_DOWN]);
      p2_boost <= keys_nx[K_RSHIFT];
      start_pulse <= evt_valid && !evt_break && mask[K_ENTER] && !keys[K_ENTER];
    end
  end
endmodule

// File: tb/tb_kbd_drive_decoder.sv
// tb_kbd_drive_decoder: directed scan-code sequences with hand-computed drive outputs
module tb_kbd_drive_decoder;
  localparam int unsigned TMO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic rx_err = 1'b0;
  logic [1:0] p1_h_code, p1_v_code, p2_h_code, p2_v_code;
  logic p1_boost, p2_boost, start_pulse;
  int checks = 0;
  int errors = 0;
  logic [10:0] exp_v;
  wire [10:0] outs = {p1_h_code, p1_v_code, p1_boost, p2_h_code, p2_v_code, p2_boost, start_pulse};
  kbd_drive_decoder #(.PREFIX_TIMEOUT(TMO), .PAUSE_SKIP(3'd7)) dut (
    .clk(clk),
    .rst(rst),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte),
    .rx_err(rx_err),
    .p1_h_code(p1_h_code),
    .p1_v_code(p1_v_code),
    .p1_boost(p1_boost),
    .p2_h_code(p2_h_code),
    .p2_v_code(p2_v_code),
    .p2_boost(p2_boost),
    .start_pulse(start_pulse)
  );
  always #5 clk = ~clk;
  function automatic logic [10:0] o(input logic [1:0] h1, input logic [1:0] v1, input logic b1,
                                    input logic [1:0] h2, input logic [1:0] v2, input logic b2, input logic s);
    o = {h1, v1, b1, h2, v2, b2, s};
  endfunction
  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== 11'd0) begin errors++; $display("FAIL reset got %h exp %h", outs, 11'd0); end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_p1;
    send(8'h1D);
    exp_v = o(2'd0, 2'd1, 0, 2'd0, 2'd0, 0, 0);
    checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL p1_w got %h exp %h", outs, exp_v); end
    send(8'h1C);
    exp_v = o(2'd1, 2'd1, 0, 2'd0, 2'd0, 0, 0);
    checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL p1_wa got %h exp %h", outs, exp_v); end
    send(8'hF0); send(8'h1D);
    exp_v = o(2'd1, 2'd0, 0, 2'd0, 2'd0, 0, 0);
    checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL p1_w_rel got %h exp %h", outs, exp_v); end
    send(8'h1D); send(8'h1B);
    exp_v = o(2'd1, 2'd0, 0, 2'd0, 2'd0, 0, 0);
    checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL p1_ws_both got %h exp %h", outs, exp_v); end
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h1D); send(8'hF0); send(8'h1B);
    checks++;
    if (outs !== 11'd0) begin errors++; $display("FAIL p1_clear got %h exp %h", outs, 11'd0); end
  endtask
  task automatic test_p2;
    send(8'hE0); send(8'h6B);
    exp_v = o(2'd0, 2'd0, 0, 2'd1, 2'd0, 0, 0);
    checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL p2_left got %h exp %h", outs, exp_v); end
    send(8'hE0); send(8'h74);
    checks++;
    if (outs !== 11'd0) begin errors++; $display("FAIL p2_lr_both got %h exp %h", outs, 11'd0); end
    send(8'hE0); send(8'hF0); send(8'h6B);
    exp_v = o(2'd0, 2'd0, 0, 2'd2, 2'd0, 0, 0);
    checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL p2_right got %h exp %h", outs, exp_v); end
    send(8'hE0); send(8'h1D);
    checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL ext_mismatch got %h exp %h", outs, exp_v); end
    send(8'hE0); send(8'hF0); send(8'h74);
    checks++;
    if (outs !== 11'd0) begin errors++; $display("FAIL p2_clear got %h exp %h", outs, 11'd0); end
  endtask
  task automatic test_start;
    logic [7:0] seq [7];
    logic exp_s [7];
    seq = '{8'h5A, 8'h5A, 8'h5A, 8'hF0, 8'h5A, 8'h5A, 8'h00};
    exp_s = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      if (i < 6) send(seq[i]);
      else @(negedge clk);
      checks++;
      if (start_pulse !== exp_s[i])
        begin errors++; $display("FAIL start_step%0d got %b exp %b", i, start_pulse, exp_s[i]); end
    end
    send(8'hF0); send(8'h5A);
  endtask
  task automatic test_pause;
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) begin
      send(seq[i]);
      checks++;
      if (outs !== 11'd0) begin errors++; $display("FAIL pause_byte%0d got %h exp %h", i, outs, 11'd0); end
    end
    send(8'h12);
    exp_v = o(2'd0, 2'd0, 1, 2'd0, 2'd0, 0, 0);
    checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL boost_after_pause got %h exp %h", outs, exp_v); end
    send(8'hF0); send(8'h12);
    send(8'hE1);
    for (int i = 0; i < 7; i++) send(8'h1C);
    send(8'h1D);
    exp_v = o(2'd0, 2'd1, 0, 2'd0, 2'd0, 0, 0);
    checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL skip_count got %h exp %h", outs, exp_v); end
    send(8'hF0); send(8'h1D);
  endtask
  task automatic test_timeout;
    send(8'hE0);
    repeat (TMO - 1) @(negedge clk);
    send(8'h75);
    exp_v = o(2'd0, 2'd0, 0, 2'd0, 2'd1, 0, 0);
    checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL prefix_just_in_time got %h exp %h", outs, exp_v); end
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0);
    repeat (TMO) @(negedge clk);
    send(8'h75);
    checks++;
    if (outs !== 11'd0) begin errors++; $display("FAIL prefix_timeout got %h exp %h", outs, 11'd0); end
  endtask
  task automatic test_error;
    send(8'hF0);
    rx_err = 1'b1;
    @(negedge clk);
    rx_err = 1'b0;
    send(8'h1B);
    exp_v = o(2'd0, 2'd2, 0, 2'd0, 2'd0, 0, 0);
    checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL err_then_make got %h exp %h", outs, exp_v); end
    send(8'hF0);
    rx_err = 1'b1;
    send(8'h1B);
    rx_err = 1'b0;
    checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL err_wins got %h exp %h", outs, exp_v); end
    send(8'h1B);
    checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL err_repeat got %h exp %h", outs, exp_v); end
    send(8'hF0); send(8'h1B);
    checks++;
    if (outs !== 11'd0) begin errors++; $display("FAIL err_release got %h exp %h", outs, 11'd0); end
  endtask
  task automatic test_independence;
    send(8'h1C); send(8'hE0); send(8'h75); send(8'h12); send(8'h59);
    exp_v = o(2'd1, 2'd0, 1, 2'd0, 2'd1, 1, 0);
    checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL both_players got %h exp %h", outs, exp_v); end
    send(8'hF0); send(8'h12);
    exp_v = o(2'd1, 2'd0, 0, 2'd0, 2'd1, 1, 0);
    checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL p1_boost_rel got %h exp %h", outs, exp_v); end
  endtask
  task automatic test_reset_mid;
    send(8'hE0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (outs !== 11'd0) begin errors++; $display("FAIL reset_mid got %h exp %h", outs, 11'd0); end
    send(8'h75);
    checks++;
    if (outs !== 11'd0) begin errors++; $display("FAIL reset_mid_prefix got %h exp %h", outs, 11'd0); end
    send(8'hF0); send(8'h1D);
    checks++;
    if (outs !== 11'd0) begin errors++; $display("FAIL orphan_break got %h exp %h", outs, 11'd0); end
    send(8'h1D);
    exp_v = o(2'd0, 2'd1, 0, 2'd0, 2'd0, 0, 0);
    checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL after_reset_make got %h exp %h", outs, exp_v); end
  endtask
  initial begin
    @(negedge clk);
    test_reset;
    test_p1;
    test_p2;
    test_start;
    test_pause;
    test_timeout;
    test_error;
    test_independence;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
